// File: rtl/mux_pkg.sv
// Shared constants for the registered N:1 multiplexer and its arbiter.
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority encoder: grants the first requester at or after ptr, wrapping mod N.
module rr_arbiter #(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_vld,
    output logic [SELW-1:0] gnt_idx
);

    int idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = SELW'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// N:1 W-bit multiplexer with valid/ready on every channel and a one-entry output register.
module mux_n_reg
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    parameter  int MODE = 0,
    localparam int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    input  logic [SELW-1:0] sel,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    input  logic            out_ready,
    output logic [SELW-1:0] grant_idx
);

    logic            load;
    logic            cand_vld;
    logic [SELW-1:0] cand_idx;
    logic [W-1:0]    cand_data;
    logic            xfer;

    // No handshake is offered while reset is asserted, since the register would discard it.
    assign load = (~out_valid | out_ready) & rst_n;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SELW-1:0] rr_ptr;
            logic            unused_sel;

            assign unused_sel = ^sel;

            rr_arbiter #(.N(N)) u_arb (
                .req     (in_valid),
                .ptr     (rr_ptr),
                .gnt_vld (cand_vld),
                .gnt_idx (cand_idx)
            );

            // Pointer only moves on a real transfer, so a stalled grant keeps its place.
            always_ff @(posedge clk) begin
                if (!rst_n)
                    rr_ptr <= '0;
                else if (xfer)
                    rr_ptr <= (cand_idx == SELW'(N - 1)) ? '0 : cand_idx + 1'b1;
            end
        end else begin : g_sel
            assign cand_vld = ({1'b0, sel} < (SELW + 1)'(N));
            assign cand_idx = sel;
        end
    endgenerate

    always_comb begin
        in_ready  = '0;
        cand_data = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_vld && cand_idx == SELW'(i)) begin
                in_ready[i] = load;
                cand_data   = in_data[i*W +: W];
            end
        end
    end

    assign xfer = cand_vld & load & in_valid[cand_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant_idx <= '0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data  <= cand_data;
                grant_idx <= cand_idx;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_reg.sv
// Randomised and directed bench for mux_n_reg in both select and round-robin modes.
module tb_mux_n_reg;
    import mux_pkg::*;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int SELW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    s_in_valid, s_in_ready, r_in_valid, r_in_ready;
    logic [N*W-1:0]  s_in_data, r_in_data;
    logic [SELW-1:0] s_sel, r_sel, s_grant, r_grant;
    logic            s_out_valid, s_out_ready, r_out_valid, r_out_ready;
    logic [W-1:0]    s_out_data, r_out_data;

    mux_n_reg #(.N(N), .W(W), .MODE(MODE_SEL)) dut_sel (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_ready(s_in_ready), .sel(s_sel), .out_valid(s_out_valid),
        .out_data(s_out_data), .out_ready(s_out_ready), .grant_idx(s_grant)
    );

    mux_n_reg #(.N(N), .W(W), .MODE(MODE_RR)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid), .in_data(r_in_data),
        .in_ready(r_in_ready), .sel(r_sel), .out_valid(r_out_valid),
        .out_data(r_out_data), .out_ready(r_out_ready), .grant_idx(r_grant)
    );

    int checks   = 0;
    int failures = 0;

    bit         ms_valid, mr_valid;
    bit [W-1:0] ms_data, mr_data;
    int         ms_grant, mr_grant, mr_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    // Check in_ready against the model, advance the model, then check registered outputs.
    task automatic tick();
        int c;
        bit ld;
        logic [N-1:0] exp_rdy;
        #2;
        ld = rst_n && (!ms_valid || s_out_ready);
        c  = int'(s_sel);
        exp_rdy = '0;
        if (ld && c < N) exp_rdy[c] = 1'b1;
        chk("s_in_ready", 32'(s_in_ready), 32'(exp_rdy));
        if (!rst_n) begin
            ms_valid = 0; ms_data = '0; ms_grant = 0;
        end else if (ld) begin
            ms_valid = (c < N) && s_in_valid[c];
            if (ms_valid) begin
                ms_data  = s_in_data[c*W +: W];
                ms_grant = c;
            end
        end

        ld = rst_n && (!mr_valid || r_out_ready);
        c  = rr_pick(r_in_valid, mr_ptr);
        exp_rdy = '0;
        if (ld && c >= 0) exp_rdy[c] = 1'b1;
        chk("r_in_ready", 32'(r_in_ready), 32'(exp_rdy));
        if (!rst_n) begin
            mr_valid = 0; mr_data = '0; mr_grant = 0; mr_ptr = 0;
        end else if (ld) begin
            mr_valid = (c >= 0);
            if (mr_valid) begin
                mr_data  = r_in_data[c*W +: W];
                mr_grant = c;
                mr_ptr   = (c + 1) % N;
            end
        end

        @(posedge clk);
        #1;
        chk("s_out_valid", 32'(s_out_valid), 32'(ms_valid));
        chk("s_out_data",  32'(s_out_data),  32'(ms_data));
        chk("s_grant_idx", 32'(s_grant),     32'(ms_grant));
        chk("r_out_valid", 32'(r_out_valid), 32'(mr_valid));
        chk("r_out_data",  32'(r_out_data),  32'(mr_data));
        chk("r_grant_idx", 32'(r_grant),     32'(mr_grant));
    endtask

    initial begin
        logic [SELW-1:0] rr_seq [5];
        rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        ms_valid = 0; ms_data = '0; ms_grant = 0;
        mr_valid = 0; mr_data = '0; mr_grant = 0; mr_ptr = 0;

        // Reset with every input active
        rst_n = 0;
        s_in_valid = '1; s_in_data = 32'hDEADBEEF; s_sel = 2'd1; s_out_ready = 1;
        r_in_valid = '1; r_in_data = 32'h12345678; r_sel = 2'd0; r_out_ready = 1;
        repeat (2) tick();
        chk("rst_s_valid", 32'(s_out_valid), 0);
        chk("rst_s_data",  32'(s_out_data),  0);
        chk("rst_r_grant", 32'(r_grant),     0);
        chk("rst_r_ready", 32'(r_in_ready),  0);
        rst_n = 1;
        r_in_valid = '0;

        // Select-mode pass-through
        s_sel = 2'd2; s_in_valid = 4'b0100; s_in_data = 32'h11A52233; s_out_ready = 1;
        tick();
        chk("pass_valid", 32'(s_out_valid), 1);
        chk("pass_data",  32'(s_out_data),  32'hA5);
        chk("pass_grant", 32'(s_grant),     2);

        // Backpressure holds the word, then next word loads with no bubble
        s_out_ready = 0; s_in_data = 32'h005A0000;
        repeat (3) begin
            tick();
            chk("bp_hold", 32'(s_out_data), 32'hA5);
        end
        chk("bp_ready", 32'(s_in_ready), 0);
        s_out_ready = 1;
        tick();
        chk("bp_release", 32'(s_out_data), 32'h5A);
        s_in_valid = '0;

        // Round-robin fairness with all channels valid
        r_in_valid = 4'b1111; r_in_data = 32'h44332211; r_out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_fair", 32'(r_grant), 32'(rr_seq[i]));
        end

        // Sparse requests, then a stall while a new channel appears
        r_in_valid = 4'b1001;
        tick(); chk("rr_sparse_a", 32'(r_grant), 3);
        tick(); chk("rr_sparse_b", 32'(r_grant), 0);
        r_out_ready = 0;
        repeat (2) tick();
        r_in_valid = 4'b1011; r_out_ready = 1;
        tick(); chk("rr_after_stall", 32'(r_grant), 1);

        // Reset while stalled drops the word and the pointer
        r_in_valid = 4'b1111; r_out_ready = 0;
        repeat (2) tick();
        rst_n = 0;
        tick();
        chk("mid_rst_valid", 32'(r_out_valid), 0);
        chk("mid_rst_data",  32'(r_out_data),  0);
        rst_n = 1; r_in_valid = 4'b1010; r_out_ready = 1;
        tick();
        chk("mid_rst_first", 32'(r_grant), 1);

        // Random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            rst_n       = ($urandom_range(0, 39) != 0);
            s_in_valid  = N'($urandom);
            s_in_data   = $urandom;
            s_sel       = SELW'($urandom);
            s_out_ready = ($urandom_range(0, 3) != 0);
            r_in_valid  = N'($urandom);
            r_in_data   = $urandom;
            r_sel       = SELW'($urandom);
            r_out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
